// File: rtl/ball_motion.sv
// Pong ball-position engine: advances the ball once per Enable tick, bouncing off walls and paddles.
// Optional speed-up on paddle hits is enabled by defining BALL_SPEEDUP_EN.
module ball_motion #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_L_X  = 16,
  parameter int PADDLE_R_X  = 616,
  parameter int PAUSE_TICKS = 60,
  parameter int MAX_SPEED   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Serve,
  input  logic [9:0] PaddleL,
  input  logic [9:0] PaddleR,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic       PointL,
  output logic       PointR,
  output logic       Playing
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SCORED = 2'd2
  } state_t;

  localparam int CW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
  localparam int SW = (MAX_SPEED > 1) ? $clog2(MAX_SPEED + 1) : 1;

  localparam logic [10:0] H_RES_W  = 11'(H_RES);
  localparam logic [10:0] V_RES_W  = 11'(V_RES);
  localparam logic [10:0] BS_W     = 11'(BALL_SIZE);
  localparam logic [10:0] PH_W     = 11'(PADDLE_H);
  localparam logic [10:0] PR_X_W   = 11'(PADDLE_R_X);
  localparam logic [10:0] FACE_L_W = 11'(PADDLE_L_X + PADDLE_W);

  localparam logic [9:0] X_CTR   = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CTR   = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] X_MAX   = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0] Y_MAX   = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0] X_HIT_R = 10'(PADDLE_R_X - BALL_SIZE);
  localparam logic [9:0] X_HIT_L = 10'(PADDLE_L_X + PADDLE_W);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_TICKS - 1);

  state_t        state_r, state_nxt_s;
  logic [9:0]    ball_x_r, ball_y_r, ball_x_nxt_s, ball_y_nxt_s;
  logic          dir_x_r, dir_y_r, dir_x_nxt_s, dir_y_nxt_s;  // 1 = right / down
  logic [CW-1:0] pause_r, pause_nxt_s;
  logic          point_l_r, point_r_r, point_l_nxt_s, point_r_nxt_s;
  logic          playing_r;
  logic [SW-1:0] step_s;

  logic [10:0] bx_s, by_s, s_s, pl_s, pr_s;
  logic [9:0]  s10_s;
  logic        overlap_l_s, overlap_r_s, hit_l_s, hit_r_s, miss_l_s, miss_r_s;
  logic        pause_done_s;

  assign bx_s  = {1'b0, ball_x_r};
  assign by_s  = {1'b0, ball_y_r};
  assign pl_s  = {1'b0, PaddleL};
  assign pr_s  = {1'b0, PaddleR};
  assign s_s   = 11'(step_s);
  assign s10_s = 10'(step_s);

  // Paddle overlap uses the pre-update Y; a ball already past a face never hits it.
  assign overlap_r_s = (by_s + BS_W > pr_s) && (by_s < pr_s + PH_W);
  assign overlap_l_s = (by_s + BS_W > pl_s) && (by_s < pl_s + PH_W);
  assign hit_r_s  = dir_x_r && (bx_s + BS_W <= PR_X_W) && (bx_s + BS_W + s_s >= PR_X_W) && overlap_r_s;
  assign hit_l_s  = !dir_x_r && (bx_s >= FACE_L_W) && (bx_s <= FACE_L_W + s_s) && overlap_l_s;
  assign miss_r_s = dir_x_r && !hit_r_s && (bx_s + BS_W + s_s >= H_RES_W);
  assign miss_l_s = !dir_x_r && !hit_l_s && (bx_s <= s_s);
  assign pause_done_s = (pause_r == PAUSE_LAST);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (Serve) state_nxt_s = MOVE;
        else       state_nxt_s = IDLE;
      end
      MOVE: begin
        if (Enable && (miss_r_s || miss_l_s)) state_nxt_s = SCORED;
        else                                  state_nxt_s = MOVE;
      end
      SCORED: begin
        if (Enable && pause_done_s) state_nxt_s = IDLE;
        else                        state_nxt_s = SCORED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Ball position, direction, pause count and point pulses for the next cycle
  always_comb begin
    ball_x_nxt_s  = ball_x_r;
    ball_y_nxt_s  = ball_y_r;
    dir_x_nxt_s   = dir_x_r;
    dir_y_nxt_s   = dir_y_r;
    pause_nxt_s   = pause_r;
    point_l_nxt_s = 1'b0;
    point_r_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        ball_x_nxt_s = X_CTR;
        ball_y_nxt_s = Y_CTR;
        pause_nxt_s  = {CW{1'b0}};
      end
      MOVE: begin
        if (Enable) begin
          if (dir_y_r) begin
            if (by_s + BS_W + s_s >= V_RES_W) begin
              ball_y_nxt_s = Y_MAX;
              dir_y_nxt_s  = 1'b0;
            end else begin
              ball_y_nxt_s = ball_y_r + s10_s;
            end
          end else begin
            if (by_s <= s_s) begin
              ball_y_nxt_s = 10'd0;
              dir_y_nxt_s  = 1'b1;
            end else begin
              ball_y_nxt_s = ball_y_r - s10_s;
            end
          end
          // After a miss the serve heads toward the player who just scored.
          if (hit_r_s) begin
            ball_x_nxt_s = X_HIT_R;
            dir_x_nxt_s  = 1'b0;
          end else if (hit_l_s) begin
            ball_x_nxt_s = X_HIT_L;
            dir_x_nxt_s  = 1'b1;
          end else if (miss_r_s) begin
            ball_x_nxt_s  = X_MAX;
            dir_x_nxt_s   = 1'b0;
            point_l_nxt_s = 1'b1;
          end else if (miss_l_s) begin
            ball_x_nxt_s  = 10'd0;
            dir_x_nxt_s   = 1'b1;
            point_r_nxt_s = 1'b1;
          end else if (dir_x_r) begin
            ball_x_nxt_s = ball_x_r + s10_s;
          end else begin
            ball_x_nxt_s = ball_x_r - s10_s;
          end
        end else begin
          ball_x_nxt_s = ball_x_r;
        end
      end
      SCORED: begin
        if (Enable) begin
          if (pause_done_s) begin
            pause_nxt_s  = {CW{1'b0}};
            ball_x_nxt_s = X_CTR;
            ball_y_nxt_s = Y_CTR;
          end else begin
            pause_nxt_s = pause_r + CW'(1'b1);
          end
        end else begin
          pause_nxt_s = pause_r;
        end
      end
      default: begin
        ball_x_nxt_s = X_CTR;
        ball_y_nxt_s = Y_CTR;
        pause_nxt_s  = {CW{1'b0}};
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ball_x_r  <= X_CTR;
      ball_y_r  <= Y_CTR;
      dir_x_r   <= 1'b1;
      dir_y_r   <= 1'b1;
      pause_r   <= {CW{1'b0}};
      point_l_r <= 1'b0;
      point_r_r <= 1'b0;
      playing_r <= 1'b0;
    end else begin
      ball_x_r  <= ball_x_nxt_s;
      ball_y_r  <= ball_y_nxt_s;
      dir_x_r   <= dir_x_nxt_s;
      dir_y_r   <= dir_y_nxt_s;
      pause_r   <= pause_nxt_s;
      point_l_r <= point_l_nxt_s;
      point_r_r <= point_r_nxt_s;
      playing_r <= (state_nxt_s == MOVE);
    end
  end

`ifdef BALL_SPEEDUP_EN
  localparam logic [SW-1:0] STEP_MAX = SW'(MAX_SPEED);
  logic [SW-1:0] step_r, step_nxt_s;

  assign step_s = step_r;

  // Step grows by one per paddle hit up to the ceiling and restarts at 1 in IDLE
  always_comb begin
    step_nxt_s = step_r;
    if (state_nxt_s == IDLE) begin
      step_nxt_s = SW'(1'b1);
    end else if ((state_r == MOVE) && Enable && (hit_r_s || hit_l_s)) begin
      if (step_r >= STEP_MAX) step_nxt_s = STEP_MAX;
      else                    step_nxt_s = step_r + SW'(1'b1);
    end else begin
      step_nxt_s = step_r;
    end
  end

  // Step register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      step_r <= SW'(1'b1);
    end else begin
      step_r <= step_nxt_s;
    end
  end
`else
  assign step_s = SW'(1'b1);
`endif

  assign BallX   = ball_x_r;
  assign BallY   = ball_y_r;
  assign PointL  = point_l_r;
  assign PointR  = point_r_r;
  assign Playing = playing_r;

endmodule
